exprom_ctrl: RTL

Access controller for the PCI expansion-ROM array (32-bit word, 512 words, four byte-wide slices sharing one write enable). Arbitrates two requesters onto the single ROM port: the PCI target read path and the host loader, which reads and writes the image. Sequences the ROM's one-cycle synchronous read. Turns partial-byte loader writes into read-modify-write, because the array has no byte enables.

---
 rtl/exprom_pkg.sv | 29 ++
 rtl/exprom_ctrl_if.sv | 41 ++++
 rtl/exprom_ctrl_arb.sv | 23 ++
 rtl/exprom_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/exprom_pkg.sv
// Shared types and helpers for the expansion-ROM access controller.
// Holds the FSM encoding, default widths and the byte-lane merge used by read-modify-write.
package exprom_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      ACK  = 3'd4
   } state_t;

   // Lanes with be=1 take the new byte, all others keep the word read from the array.
   function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_word,
                                                  input logic [DATA_W-1:0] new_word,
                                                  input logic [BE_W-1:0]   be);
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int i = 0; i < BE_W; i++) begin
         if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/exprom_ctrl_if.sv
// Requester and ROM-port signals of the expansion-ROM controller.
// Both requesters use level req held until a one-cycle ack; req is dropped at the edge that samples ack.
interface exprom_ctrl_if;
   import exprom_pkg::*;

   logic              t_req;
   logic [ADDR_W-1:0] t_addr;
   logic              t_ack;
   logic [DATA_W-1:0] t_rdata;

   logic              h_req;
   logic              h_we;
   logic [ADDR_W-1:0] h_addr;
   logic [DATA_W-1:0] h_wdata;
   logic [BE_W-1:0]   h_be;
   logic              h_ack;
   logic [DATA_W-1:0] h_rdata;
   logic              h_err;
   logic              wp;

   logic [ADDR_W-1:0] rom_address;
   logic              rom_enable;
   logic              rom_wren;
   logic [DATA_W-1:0] rom_dinp;
   logic [DATA_W-1:0] rom_dout;

   // Environment side: requesters plus the ROM array.
   modport master (
      output t_req, t_addr, h_req, h_we, h_addr, h_wdata, h_be, wp, rom_dout,
      input  t_ack, t_rdata, h_ack, h_rdata, h_err,
      input  rom_address, rom_enable, rom_wren, rom_dinp
   );

   // Controller side.
   modport slave (
      input  t_req, t_addr, h_req, h_we, h_addr, h_wdata, h_be, wp, rom_dout,
      output t_ack, t_rdata, h_ack, h_rdata, h_err,
      output rom_address, rom_enable, rom_wren, rom_dinp
   );

endinterface

// File: rtl/exprom_ctrl_arb.sv
// Two-input round-robin arbiter: on a tie the requester not granted last wins.
// req[0]=target, req[1]=host; the last-grant register resets to host.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_host;

   always_comb begin
      grant = req;
      if (req == 2'b11) grant = last_host ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk) begin
      if (rst)          last_host <= 1'b1;
      else if (advance) last_host <= grant[1];
   end

endmodule

// File: rtl/exprom_ctrl.sv
// Arbitrates target reads and host loader accesses onto the single expansion-ROM port,
// sequencing the one-cycle synchronous read and read-modify-write for partial byte enables.
module exprom_ctrl
   import exprom_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   exprom_ctrl_if.slave        bus,
   output logic                busy,
   output state_t              dbg_state
);

   state_t            state, next_state;
   logic [1:0]        req, grant;
   logic              advance;
   logic              sel_host;
   logic              l_we, l_wp;
   logic [DATA_W-1:0] l_wdata;
   logic [BE_W-1:0]   l_be;

   assign req     = {bus.h_req, bus.t_req};
   assign advance = (state == IDLE) && (req != 2'b00);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (advance),
      .grant   (grant)
   );

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (grant[1]) begin
               if (!bus.h_we)                             next_state = RD;
               else if (bus.wp || bus.h_be == '0)         next_state = ACK;
               else if (bus.h_be == {BE_W{1'b1}})         next_state = WR;
               else                                       next_state = RD;
            end else if (grant[0]) begin
               next_state = RD;
            end
         end
         RD:      next_state = CAP;
         CAP:     next_state = (sel_host && l_we) ? WR : ACK;
         WR:      next_state = ACK;
         ACK:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         sel_host        <= 1'b0;
         l_we            <= 1'b0;
         l_wp            <= 1'b0;
         l_wdata         <= '0;
         l_be            <= '0;
         bus.rom_address <= '0;
         bus.rom_dinp    <= '0;
         bus.t_rdata     <= '0;
         bus.h_rdata     <= '0;
      end else begin
         state <= next_state;
         if (advance) begin
            sel_host <= grant[1];
            l_we     <= grant[1] & bus.h_we;
            l_wp     <= bus.wp;
            l_wdata  <= bus.h_wdata;
            l_be     <= bus.h_be;
            if (next_state == RD || next_state == WR)
               bus.rom_address <= grant[1] ? bus.h_addr : bus.t_addr;
            if (next_state == WR)
               bus.rom_dinp <= bus.h_wdata;
         end
         // rom_dout carries the word addressed in RD; either merge it for a write or return it.
         if (state == CAP) begin
            if (sel_host && l_we) bus.rom_dinp <= merge_be(bus.rom_dout, l_wdata, l_be);
            else if (sel_host)    bus.h_rdata  <= bus.rom_dout;
            else                  bus.t_rdata  <= bus.rom_dout;
         end
      end
   end

   assign bus.rom_enable = !rst && (state == RD || state == WR);
   assign bus.rom_wren   = !rst && (state == WR);
   assign bus.t_ack      = !rst && (state == ACK) && !sel_host;
   assign bus.h_ack      = !rst && (state == ACK) && sel_host;
   assign bus.h_err      = bus.h_ack && l_we && l_wp;
   assign busy           = (state != IDLE);
   assign dbg_state      = state;

endmodule
